// File: rtl/alarm_pkg.sv
// Shared constants for the alarm controller and siren generator: state codes
// and default tick timing.
package alarm_pkg;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] DISARMED = 3'd0;
    localparam logic [STATE_W-1:0] ARMING   = 3'd1;
    localparam logic [STATE_W-1:0] ARMED    = 3'd2;
    localparam logic [STATE_W-1:0] ENTRY    = 3'd3;
    localparam logic [STATE_W-1:0] ALARM    = 3'd4;

    localparam int unsigned DEF_CLK_FREQ_HZ         = 100_000_000;
    localparam int unsigned DEF_ARM_DELAY_TICKS     = 20;
    localparam int unsigned DEF_ENTRY_DELAY_TICKS   = 30;
    localparam int unsigned DEF_ALARM_TIMEOUT_TICKS = 360;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: registered one-cycle tick every DIV clocks, the first
// on the DIV-th rising edge after reset.
module tick_gen #(
    parameter int unsigned DIV = 10
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int unsigned CNT_W = $clog2(DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q;
    logic             wrap;

    always_comb begin
        wrap  = (cnt_q == CNT_W'(DIV - 1));
        cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= wrap;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/alarm_controller.sv
// Arm/disarm FSM with exit delay, entry delay and alarm timeout, driven by a 2 Hz tick.
// Define AUTO_REARM_EN to return to ARMED instead of DISARMED after the alarm times out.
module alarm_controller
    import alarm_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ         = DEF_CLK_FREQ_HZ,
    parameter int unsigned ARM_DELAY_TICKS     = DEF_ARM_DELAY_TICKS,
    parameter int unsigned ENTRY_DELAY_TICKS   = DEF_ENTRY_DELAY_TICKS,
    parameter int unsigned ALARM_TIMEOUT_TICKS = DEF_ALARM_TIMEOUT_TICKS
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               arm,
    input  logic               disarm,
    input  logic               sensor,
    output logic               two_hz_enable,
    output logic               eneble_siren,
    output logic               armed_led,
    output logic [STATE_W-1:0] state
);

    localparam int unsigned TICK_DIV  = CLK_FREQ_HZ / 2;
    localparam int unsigned MAX_TICKS = max3(ARM_DELAY_TICKS, ENTRY_DELAY_TICKS,
                                             ALARM_TIMEOUT_TICKS);
    localparam int unsigned TIMER_W   = $clog2(MAX_TICKS) + 1;

`ifdef AUTO_REARM_EN
    localparam logic [STATE_W-1:0] TIMEOUT_STATE = ARMED;
`else
    localparam logic [STATE_W-1:0] TIMEOUT_STATE = DISARMED;
`endif

    logic               tick;
    logic               sensor_meta_q, sensor_sync_q;
    logic [STATE_W-1:0] state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               timer_last;

    tick_gen #(
        .DIV(TICK_DIV)
    ) u_tick_gen (
        .clock(clock),
        .reset(reset),
        .tick (tick)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sensor_meta_q <= 1'b0;
            sensor_sync_q <= 1'b0;
        end else begin
            sensor_meta_q <= sensor;
            sensor_sync_q <= sensor_meta_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= DISARMED;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    assign timer_last = (timer_q == TIMER_W'(1));

    // Disarm is checked first so it wins over every other input in the same cycle.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        if (disarm) begin
            state_d = DISARMED;
        end else begin
            case (state_q)
                DISARMED: begin
                    if (arm) begin
                        state_d = ARMING;
                        timer_d = TIMER_W'(ARM_DELAY_TICKS);
                    end
                end
                ARMING: begin
                    if (tick) begin
                        if (timer_last) state_d = ARMED;
                        else            timer_d = timer_q - TIMER_W'(1);
                    end
                end
                ARMED: begin
                    if (sensor_sync_q) begin
                        state_d = ENTRY;
                        timer_d = TIMER_W'(ENTRY_DELAY_TICKS);
                    end
                end
                ENTRY: begin
                    if (tick) begin
                        if (timer_last) begin
                            state_d = ALARM;
                            timer_d = TIMER_W'(ALARM_TIMEOUT_TICKS);
                        end else begin
                            timer_d = timer_q - TIMER_W'(1);
                        end
                    end
                end
                ALARM: begin
                    if (tick) begin
                        if (timer_last) state_d = TIMEOUT_STATE;
                        else            timer_d = timer_q - TIMER_W'(1);
                    end
                end
                default: state_d = DISARMED;
            endcase
        end
    end

    always_comb begin
        two_hz_enable = tick;
        eneble_siren  = (state_q == ALARM);
        armed_led     = (state_q == ARMED) || (state_q == ENTRY) || (state_q == ALARM);
        state         = state_q;
    end

endmodule

// File: tb/tb_alarm_controller.sv
// Randomized and directed bench for alarm_controller against a tick-level reference model.
module tb_alarm_controller;
    import alarm_pkg::*;

    localparam int unsigned TB_CLK_HZ  = 20;
    localparam int          TB_DIV     = 10;
    localparam int          TB_ARM     = 2;
    localparam int          TB_ENTRY   = 3;
    localparam int          TB_TIMEOUT = 4;

    logic               clock = 1'b0;
    logic               reset;
    logic               arm, disarm, sensor;
    logic               two_hz_enable, eneble_siren, armed_led;
    logic [STATE_W-1:0] state;

    int errors = 0;
    int checks = 0;

    // Reference model state: mode, ticks still to wait, edges since release
    int m_state, m_left, m_cyc;
    bit m_tick;
    bit h1, h2;  // sensor samples taken one and two edges ago

    alarm_controller #(
        .CLK_FREQ_HZ        (TB_CLK_HZ),
        .ARM_DELAY_TICKS    (TB_ARM),
        .ENTRY_DELAY_TICKS  (TB_ENTRY),
        .ALARM_TIMEOUT_TICKS(TB_TIMEOUT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .arm          (arm),
        .disarm       (disarm),
        .sensor       (sensor),
        .two_hz_enable(two_hz_enable),
        .eneble_siren (eneble_siren),
        .armed_led    (armed_led),
        .state        (state)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_state = 0;
        m_left  = 0;
        m_cyc   = 0;
        m_tick  = 1'b0;
        h1      = 1'b0;
        h2      = 1'b0;
    endfunction

    // One rising edge: apply the transition rules using the tick visible before the edge
    // and the sensor level sampled two edges earlier.
    function automatic void model_step();
        bit tick_seen, sync;
        tick_seen = m_tick;
        sync      = h2;
        if (disarm) begin
            m_state = 0;
        end else if (m_state == 0) begin
            if (arm) begin
                m_state = 1;
                m_left  = TB_ARM;
            end
        end else if (m_state == 2) begin
            if (sync) begin
                m_state = 3;
                m_left  = TB_ENTRY;
            end
        end else if (tick_seen) begin
            if (m_left > 1) begin
                m_left--;
            end else if (m_state == 1) begin
                m_state = 2;
            end else if (m_state == 3) begin
                m_state = 4;
                m_left  = TB_TIMEOUT;
            end else begin
`ifdef AUTO_REARM_EN
                m_state = 2;
`else
                m_state = 0;
`endif
            end
        end
        m_cyc++;
        m_tick = (m_cyc % TB_DIV == 0);
        h2     = h1;
        h1     = sensor;
    endfunction

    task automatic cycle();
        @(posedge clock);
        model_step();
        #1;
        check("state", int'(state), m_state);
        check("tick", int'(two_hz_enable), int'(m_tick));
        check("siren", int'(eneble_siren), (m_state == 4) ? 1 : 0);
        check("led", int'(armed_led), (m_state >= 2 && m_state <= 4) ? 1 : 0);
        arm    = 1'b0;
        disarm = 1'b0;
    endtask

    task automatic run_until_state(input string tag, input int target, input int bound);
        for (int i = 0; i < bound && m_state != target; i++) cycle();
        check(tag, int'(state), target);
    endtask

    // Reset asserted between edges; outputs must clear without waiting for a clock.
    task automatic async_reset();
        #2;
        reset = 1'b1;
        #1;
        check("rst_state", int'(state), int'(DISARMED));
        check("rst_siren", int'(eneble_siren), 0);
        check("rst_led", int'(armed_led), 0);
        check("rst_tick", int'(two_hz_enable), 0);
        repeat (2) @(posedge clock);
        #3;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        reset  = 1'b1;
        arm    = 1'b0;
        disarm = 1'b0;
        sensor = 1'b0;
        repeat (2) @(posedge clock);
        #3;
        reset = 1'b0;
        model_reset();
        check("init_state", int'(state), 0);
        check("init_tick", int'(two_hz_enable), 0);

        // Prescaler alone
        repeat (25) cycle();

        // Arm just after a tick, reach ARMED
        for (int i = 0; i < 20 && !m_tick; i++) cycle();
        cycle();
        arm = 1'b1;
        cycle();
        check("arming", int'(state), int'(ARMING));
        run_until_state("armed", 2, 40);
        check("armed_led", int'(armed_led), 1);

        // Intrusion through entry delay into alarm and timeout
        sensor = 1'b1;
        repeat (3) cycle();
        check("entry", int'(state), int'(ENTRY));
        run_until_state("alarm", 4, 50);
        check("siren_on", int'(eneble_siren), 1);
`ifdef AUTO_REARM_EN
        run_until_state("timeout", 2, 60);
`else
        run_until_state("timeout", 0, 60);
`endif
        sensor = 1'b0;
        disarm = 1'b1;
        cycle();

        // Disarm on the tick that would expire ENTRY
        arm = 1'b1;
        cycle();
        run_until_state("armed2", 2, 40);
        sensor = 1'b1;
        run_until_state("entry2", 3, 10);
        sensor = 1'b0;
        for (int i = 0; i < 60 && !(m_state == 3 && m_left == 1 && m_tick); i++) cycle();
        check("pre_expiry", int'(two_hz_enable), 1);
        disarm = 1'b1;
        cycle();
        check("disarm_expiry", int'(state), 0);
        check("no_siren", int'(eneble_siren), 0);

        // arm+disarm together, sensor during ARMING, arm while ARMED
        arm    = 1'b1;
        disarm = 1'b1;
        cycle();
        check("arm_disarm", int'(state), 0);
        arm = 1'b1;
        cycle();
        sensor = 1'b1;
        repeat (4) cycle();
        sensor = 1'b0;
        check("arming_ignore", int'(state), int'(ARMING));
        run_until_state("armed3", 2, 40);
        repeat (5) cycle();
        arm = 1'b1;
        cycle();
        check("arm_in_armed", int'(state), int'(ARMED));

        // Async reset mid-ALARM, then tick phase restarts
        sensor = 1'b1;
        run_until_state("entry3", 3, 10);
        sensor = 1'b0;
        run_until_state("alarm3", 4, 50);
        cycle();
        async_reset();
        repeat (12) cycle();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            arm    = ($urandom_range(0, 29) == 0);
            disarm = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 39) == 0) sensor = ~sensor;
            if ($urandom_range(0, 599) == 0) async_reset();
            else cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
